dffr_fifo: RTL and testbench

Parametrised synchronous FIFO for the RV523 datapath, built on a new width-parametrised, asynchronously-resettable edge-triggered register (`dffr`) that succeeds the bare single-bit transparent latch cell. It decouples producer/consumer stages (e.g. fetch → decode, LSU → bus) with a valid/ready handshake, a one-cycle registered latency and a synchronous flush. It maps onto the discrete-cell library: storage and pointers in `dffr`, control in NAND/NOR/AOI/OAI gates.

---
 rtl/rv523_pkg.sv | 28 ++
 rtl/dffr.sv | 29 ++
 rtl/dffr_fifo.sv | 116 +++++++++++
 tb/tb_dffr_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv523_pkg.sv
// Shared definitions for the RV523 discrete-cell datapath blocks.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package rv523_pkg;

    // Value a dffr cell powers up to and returns to on nRST, per bit.
    localparam logic DFFR_RESET_BIT = 1'b0;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Queue pointer width: index bits plus one wrap bit that tells
    // full apart from empty when the index bits match.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dffr.sv
// Width-parametrised rising-edge register, async active-low clear, load enable.
// Latency: D captured at the rising CLK edge with EN=1, visible on Q right after.
// Backpressure: none; EN=0 holds the stored value indefinitely.
module dffr
    import rv523_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFFR_RESET_BIT}}
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // The library cell builds this from a master latch open on CLK low and a
    // slave latch open on CLK high; the pair behaves as one edge-triggered
    // register, which is what is described here. nRST clears both halves
    // without waiting for a clock.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            Q <= RESET_VAL;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/dffr_fifo.sv
// Synchronous valid/ready FIFO on dffr storage rows and wrap-bit pointers.
// Latency: a word pushed at edge N is on OUT_DATA with OUT_VALID=1 after edge N.
// Backpressure: IN_READY = !full from registered pointers only; no OUT_READY bypass.
module dffr_fifo
    import rv523_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = ptr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    input  logic             FLUSH,
    output logic [CW-1:0]    COUNT
);

    // Index bits address a row; the bit above them is the wrap flag.
    localparam int AW = clog2(DEPTH);

    logic [CW-1:0]    wp;
    logic [CW-1:0]    rp;
    logic [CW-1:0]    wp_d;
    logic [CW-1:0]    rp_d;
    logic             wp_en;
    logic             rp_en;
    logic [AW-1:0]    wp_idx;
    logic [AW-1:0]    rp_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] row_we;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign wp_idx = wp[AW-1:0];
    assign rp_idx = rp[AW-1:0];

    // Status decodes look at the registered pointers only, so IN_READY,
    // OUT_VALID and COUNT never depend combinationally on any input.
    always_comb begin
        empty     = (wp == rp);
        full      = (wp_idx == rp_idx) && (wp[AW] != rp[AW]);
        IN_READY  = !full;
        OUT_VALID = !empty;
        COUNT     = wp - rp;
    end

    // Handshakes; FLUSH wins over both when the pointers are updated.
    always_comb begin
        push = IN_VALID & IN_READY;
        pop  = OUT_VALID & OUT_READY;
    end

    // Next-pointer logic: increment on a handshake, return to zero on FLUSH.
    // Pointers wrap naturally at 2*DEPTH through the CW-bit add.
    always_comb begin
        wp_en = push | FLUSH;
        rp_en = pop  | FLUSH;
        wp_d  = FLUSH ? '0 : wp + CW'(1);
        rp_d  = FLUSH ? '0 : rp + CW'(1);
    end

    dffr #(
        .WIDTH (CW)
    ) u_wp (
        .CLK  (CLK),
        .nRST (nRST),
        .EN   (wp_en),
        .D    (wp_d),
        .Q    (wp)
    );

    dffr #(
        .WIDTH (CW)
    ) u_rp (
        .CLK  (CLK),
        .nRST (nRST),
        .EN   (rp_en),
        .D    (rp_d),
        .Q    (rp)
    );

    // Write decoder: one-hot row enable at the write index. A flushed push
    // writes nothing, so the dropped word never reaches storage.
    always_comb begin
        row_we = '0;
        if (push && !FLUSH) begin
            row_we[wp_idx] = 1'b1;
        end
    end

    // Storage rows; they are cleared by nRST but deliberately not by FLUSH,
    // because stale rows are unreachable once the pointers are zeroed.
    for (genvar row = 0; row < DEPTH; row++) begin : g_row
        dffr #(
            .WIDTH (WIDTH)
        ) u_row (
            .CLK  (CLK),
            .nRST (nRST),
            .EN   (row_we[row]),
            .D    (IN_DATA),
            .Q    (mem_q[row])
        );
    end

    // Read mux selected by the registered read index; the head word is held
    // stable until a pop advances rp.
    assign OUT_DATA = mem_q[rp_idx];

endmodule

// File: tb/tb_dffr_fifo.sv
// Directed bench for dffr_fifo at WIDTH=8/DEPTH=4 and WIDTH=1/DEPTH=2.
// Each step drives inputs on the falling edge, checks outputs against a queue model,
// then lets the rising edge commit.
module tb_dffr_fifo;

    logic       clk;
    logic       rst_n;

    logic [7:0] a_in_data;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready;
    logic       a_flush;
    logic [2:0] a_count;

    logic [0:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [0:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic       b_flush;
    logic [1:0] b_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [0:0] qb[$];

    dffr_fifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) u_a (
        .CLK       (clk),
        .nRST      (rst_n),
        .IN_DATA   (a_in_data),
        .IN_VALID  (a_in_valid),
        .IN_READY  (a_in_ready),
        .OUT_DATA  (a_out_data),
        .OUT_VALID (a_out_valid),
        .OUT_READY (a_out_ready),
        .FLUSH     (a_flush),
        .COUNT     (a_count)
    );

    dffr_fifo #(
        .WIDTH (1),
        .DEPTH (2)
    ) u_b (
        .CLK       (clk),
        .nRST      (rst_n),
        .IN_DATA   (b_in_data),
        .IN_VALID  (b_in_valid),
        .IN_READY  (b_in_ready),
        .OUT_DATA  (b_out_data),
        .OUT_VALID (b_out_valid),
        .OUT_READY (b_out_ready),
        .FLUSH     (b_flush),
        .COUNT     (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 8x4 instance; called on a falling edge.
    task automatic step_a(input logic vld, input logic [7:0] dat, input logic rdy, input logic fl);
        bit         do_push;
        bit         do_pop;
        logic [7:0] tmp;
        a_in_valid  = vld;
        a_in_data   = dat;
        a_out_ready = rdy;
        a_flush     = fl;
        #1;
        chk("a_count",     32'(a_count),     32'(qa.size()));
        chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
        chk("a_in_ready",  32'(a_in_ready),  32'(qa.size() != 4));
        if (qa.size() != 0) chk("a_out_data", 32'(a_out_data), 32'(qa[0]));
        do_push = vld && (qa.size() < 4);
        do_pop  = rdy && (qa.size() > 0);
        if (fl) begin
            qa.delete();
        end else begin
            if (do_pop) tmp = qa.pop_front();
            if (do_push) qa.push_back(dat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle on the 1x2 instance; called on a falling edge.
    task automatic step_b(input logic vld, input logic [0:0] dat, input logic rdy, input logic fl);
        bit         do_push;
        bit         do_pop;
        logic [0:0] tmp;
        b_in_valid  = vld;
        b_in_data   = dat;
        b_out_ready = rdy;
        b_flush     = fl;
        #1;
        chk("b_count",     32'(b_count),     32'(qb.size()));
        chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
        chk("b_in_ready",  32'(b_in_ready),  32'(qb.size() != 2));
        if (qb.size() != 0) chk("b_out_data", 32'(b_out_data), 32'(qb[0]));
        do_push = vld && (qb.size() < 2);
        do_pop  = rdy && (qb.size() > 0);
        if (fl) begin
            qb.delete();
        end else begin
            if (do_pop) tmp = qb.pop_front();
            if (do_push) qb.push_back(dat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;

        // Power-on reset, checked without any clock edge dependence.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_a_count",     32'(a_count),     32'd0);
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_a_out_data",  32'(a_out_data),  32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_in_ready",  32'(b_in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, offer a fifth word, then drain in order.
        step_a(1'b1, 8'h11, 1'b0, 1'b0);
        step_a(1'b1, 8'h22, 1'b0, 1'b0);
        step_a(1'b1, 8'h33, 1'b0, 1'b0);
        step_a(1'b1, 8'h44, 1'b0, 1'b0);
        step_a(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);

        // Sustained push+pop at COUNT=2; pointers pass 2*DEPTH.
        step_a(1'b1, 8'h60, 1'b0, 1'b0);
        step_a(1'b1, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step_a(1'b1, 8'(8'h62 + i), 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);

        // Full with both handshakes offered: pop only, COUNT drops to 3.
        for (int i = 0; i < 4; i++) step_a(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step_a(1'b1, 8'h99, 1'b1, 1'b0);

        // Flush at COUNT=3 with push+pop asserted; 0xEE must never surface.
        step_a(1'b1, 8'hEE, 1'b1, 1'b1);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);
        step_a(1'b1, 8'h01, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);

        // Push into empty with OUT_READY high: no fall-through.
        step_a(1'b1, 8'hA5, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with three entries held.
        step_a(1'b1, 8'hC1, 1'b0, 1'b0);
        step_a(1'b1, 8'hC2, 1'b0, 1'b0);
        step_a(1'b1, 8'hC3, 1'b0, 1'b0);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_a_count",     32'(a_count),     32'd0);
        chk("midrst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_a_in_ready",  32'(a_in_ready),  32'd1);
        chk("midrst_a_out_data",  32'(a_out_data),  32'd0);
        qa.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        step_a(1'b1, 8'h5A, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);

        // Narrow, shallow instance: empty push, push+pop, full, drain.
        step_b(1'b1, 1'b1, 1'b1, 1'b0);
        step_b(1'b1, 1'b0, 1'b1, 1'b0);
        step_b(1'b1, 1'b1, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 1'b1, 1'b0);
        step_b(1'b0, 1'b0, 1'b1, 1'b0);
        step_b(1'b1, 1'b1, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b1, 1'b1);
        step_b(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
